// File: rtl/rtp_collect_pkg.sv
// rtp_collect_pkg: shared types and helpers for the RTP hit collector.
// Holds the FP infinity constant, FSM states and positive-float ordering.
package rtp_collect_pkg;

  localparam logic [31:0] FP_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] hitT;
  } hit_t;

  // Non-negative IEEE floats order like their magnitude bits.
  function automatic logic fp_pos_lt(input logic [31:0] a,
                                     input logic [31:0] b);
    return a[30:0] < b[30:0];
  endfunction

  function automatic logic fp_pos_ok(input logic [31:0] a);
    return !a[31] && !((a[30:23] == 8'hFF) && (a[22:0] != 23'd0));
  endfunction

endpackage

// File: rtl/rtp_result_ram.sv
// rtp_result_ram: simple dual-port result store, one write, one read.
// Read data is registered; a read of the address being written sees old data.
module rtp_result_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/rtp_hit_collector.sv
// rtp_hit_collector: keeps the closest hitT per ray in a result RAM.
// Define RTP_HIT_STATS_EN to add io_n_accept/io_n_update counters.
module rtp_hit_collector
  import rtp_collect_pkg::*;
#(
  parameter int NUM_RAYS = 1024,
  parameter int ID_W     = 10,
  parameter int CNT_W    = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_hit_valid,
  output logic             io_hit_ready,
  input  logic [31:0]      io_hitT,
  input  logic [31:0]      io_ray_id,
  input  logic             io_rtp_finish,
  input  logic [ID_W-1:0]  io_rd_addr,
  output logic [31:0]      io_rd_data,
  output logic             io_done,
  output logic             io_err_id,
  output logic [CNT_W-1:0] io_busy_cycles
`ifdef RTP_HIT_STATS_EN
  ,
  output logic [31:0]      io_n_accept,
  output logic [31:0]      io_n_update
`endif
);

  state_e           r_state;
  state_e           w_next;
  logic [ID_W-1:0]  r_clr_ptr;
  logic             r_s1_vld;
  logic [ID_W-1:0]  r_s1_id;
  logic [31:0]      r_s1_hitT;
  logic             r_fwd;
  logic [31:0]      r_fwd_val;
  logic             r_rd_en;
  logic             r_err;
  logic [CNT_W-1:0] r_busy;

  hit_t             w_hit;
  logic             w_acc;
  logic             w_in_rng;
  logic             w_s0_vld;
  logic             w_s1_we;
  logic             w_clr;
  logic             w_ram_we;
  logic [ID_W-1:0]  w_s0_id;
  logic [ID_W-1:0]  w_waddr;
  logic [ID_W-1:0]  w_raddr;
  logic [31:0]      w_wdata;
  logic [31:0]      w_ram_rdata;
  logic [31:0]      w_old;

  assign w_hit        = '{id: io_ray_id, hitT: io_hitT};
  assign io_hit_ready = (r_state == RUN);
  assign w_acc        = io_hit_valid && io_hit_ready;
  assign w_in_rng     = w_hit.id < 32'(NUM_RAYS);
  assign w_s0_id      = w_hit.id[ID_W-1:0];
  assign w_s0_vld     = w_acc && w_in_rng && fp_pos_ok(w_hit.hitT);

  // S1 compares against the forwarded value when the RAM read raced a write.
  assign w_old    = r_fwd ? r_fwd_val : w_ram_rdata;
  assign w_s1_we  = r_s1_vld && fp_pos_lt(r_s1_hitT, w_old);
  assign w_clr    = (r_state == CLEAR);
  assign w_ram_we = w_clr || w_s1_we;
  assign w_waddr  = w_clr ? r_clr_ptr : r_s1_id;
  assign w_wdata  = w_clr ? FP_INF : r_s1_hitT;
  assign w_raddr  = (r_state == DONE) ? io_rd_addr : w_s0_id;

  rtp_result_ram #(
    .DEPTH (NUM_RAYS),
    .AW    (ID_W)
  ) u_ram (
    .i_clk   (clock),
    .i_we    (w_ram_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CLEAR: if (r_clr_ptr == ID_W'(NUM_RAYS - 1)) w_next = RUN;
      RUN:   if (io_rtp_finish) w_next = DRAIN;
      DRAIN: if (!r_s1_vld) w_next = DONE;
      DONE:  w_next = DONE;
      default: w_next = CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_id   <= '0;
      r_s1_hitT <= '0;
      r_fwd     <= 1'b0;
      r_fwd_val <= '0;
      r_rd_en   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr) r_clr_ptr <= r_clr_ptr + ID_W'(1);
      r_s1_vld <= w_s0_vld;
      if (w_s0_vld) begin
        r_s1_id   <= w_s0_id;
        r_s1_hitT <= w_hit.hitT;
      end
      r_fwd     <= w_s0_vld && w_s1_we && (r_s1_id == w_s0_id);
      r_fwd_val <= r_s1_hitT;
      r_rd_en   <= (r_state == DONE);
      if (w_acc && !w_in_rng) r_err <= 1'b1;
      if ((r_state == RUN || r_state == DRAIN) && !(&r_busy))
        r_busy <= r_busy + CNT_W'(1);
    end
  end

  assign io_rd_data     = r_rd_en ? w_ram_rdata : 32'd0;
  assign io_done        = (r_state == DONE);
  assign io_err_id      = r_err;
  assign io_busy_cycles = r_busy;

`ifdef RTP_HIT_STATS_EN
  logic [31:0] r_n_acc;
  logic [31:0] r_n_upd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_n_acc <= '0;
      r_n_upd <= '0;
    end else begin
      if (w_acc) r_n_acc <= r_n_acc + 32'd1;
      if (w_s1_we) r_n_upd <= r_n_upd + 32'd1;
    end
  end

  assign io_n_accept = r_n_acc;
  assign io_n_update = r_n_upd;
`endif

endmodule

// File: tb/tb_rtp_hit_collector.sv
// tb_rtp_hit_collector: table-driven hits, model scoreboard for readout.
// Covers clear timing, min-keeping, drops, bad ids, finish timing, reset.
module tb_rtp_hit_collector;

  localparam int NR = 1024;
  localparam logic [31:0] INF = 32'h7F80_0000;

  typedef struct {
    logic [31:0] id;
    logic [31:0] t;
  } hv_t;

  typedef struct {
    int          addr;
    logic [31:0] exp;
  } rv_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hv = 1'b0;
  logic        ready;
  logic [31:0] ht = '0;
  logic [31:0] hid = '0;
  logic        fin = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic [63:0] busy;
`ifdef RTP_HIT_STATS_EN
  logic [31:0] n_acc;
  logic [31:0] n_upd;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_cyc = 0;

  logic [31:0] model [NR];
  logic [31:0] exp_q [$];
  int          adr_q [$];
  hv_t         hits [$];
  rv_t         rds [$];

  rtp_hit_collector dut (
    .clock          (clk),
    .reset          (rst_n),
    .io_hit_valid   (hv),
    .io_hit_ready   (ready),
    .io_hitT        (ht),
    .io_ray_id      (hid),
    .io_rtp_finish  (fin),
    .io_rd_addr     (rd_addr),
    .io_rd_data     (rd_data),
    .io_done        (done),
    .io_err_id      (err),
    .io_busy_cycles (busy)
`ifdef RTP_HIT_STATS_EN
    ,
    .io_n_accept    (n_acc),
    .io_n_update    (n_upd)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_hit(input logic [31:0] id, input logic [31:0] t);
    hv_t h;
    h.id = id;
    h.t  = t;
    hits.push_back(h);
  endtask

  task automatic add_rd(input int a, input logic [31:0] e);
    rv_t r;
    r.addr = a;
    r.exp  = e;
    rds.push_back(r);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = INF;
  endtask

  task automatic model_hit(input logic [31:0] id, input logic [31:0] t);
    logic nan;
    nan = (t[30:23] == 8'hFF) && (t[22:0] != 0);
    if (id < NR && !t[31] && !nan && t[30:0] < model[id][30:0])
      model[id] = t;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 3000);
    chk("clear_len", 64'(n), 64'(NR));
    ready_cyc = cyc;
  endtask

  task automatic drive_hit(input logic [31:0] id, input logic [31:0] t,
                           input logic f);
    hv  = 1'b1;
    hid = id;
    ht  = t;
    fin = f;
    model_hit(id, t);
    @(negedge clk);
    hv  = 1'b0;
    fin = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic finish_run(input string name);
    int n;
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    wait_done(name, 20, n);
    chk({name, "_busy"}, busy, 64'(cyc - ready_cyc));
    chk({name, "_ready"}, 64'(ready), 64'd0);
  endtask

  task automatic pop_cmp();
    int a;
    logic [31:0] e;
    a = adr_q.pop_front();
    e = exp_q.pop_front();
    chk($sformatf("rd[%0d]", a), 64'(rd_data), 64'(e));
  endtask

  task automatic read_one(input int a, input logic [31:0] e);
    rd_addr = 10'(a);
    adr_q.push_back(a);
    exp_q.push_back(e);
    @(negedge clk);
    pop_cmp();
  endtask

  task automatic sweep();
    for (int i = 0; i < NR; i++) read_one(i, model[i]);
  endtask

  task automatic rand_hits(input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = {1'b0, 8'($urandom_range(0, 254)), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) t[31] = 1'b1;
      drive_hit(32'($urandom_range(10, 20)), t, 1'b0);
    end
  endtask

  initial begin
    logic [63:0] busy_done;
    int n5;

    add_hit(32'd3,    32'h4000_0000);
    add_hit(32'd3,    32'h3F80_0000);
    add_hit(32'd3,    32'h4040_0000);
    add_hit(32'd7,    32'hBF80_0000);
    add_hit(32'd7,    32'h7FC0_0000);
    add_hit(32'd100,  32'h3F00_0000);
    add_hit(32'd100,  32'h3F00_0000);
    add_hit(32'd100,  32'h3E80_0000);
    add_hit(32'd1023, 32'h4120_0000);
    add_hit(32'd0,    32'h0000_0000);
    add_hit(32'd0,    32'h7F80_0000);
    add_hit(32'd200,  32'h7F7F_FFFF);
    add_hit(32'd200,  32'h8000_0000);

    add_rd(5,    INF);
    add_rd(3,    32'h3F80_0000);
    add_rd(7,    INF);
    add_rd(100,  32'h3E80_0000);
    add_rd(1023, 32'h4120_0000);
    add_rd(0,    32'h0000_0000);
    add_rd(200,  32'h7F7F_FFFF);

    // run 1: reset values, clear timing, table hits, readout
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_err",   64'(err),   64'd0);
    chk("rst_busy",  busy,       64'd0);
    chk("rst_rdata", 64'(rd_data), 64'd0);
    rst_n = 1'b1;
    model_clear();
    wait_ready();
    rd_addr = 10'd5;
    @(negedge clk);
    chk("rd_not_done", 64'(rd_data), 64'd0);
    foreach (hits[i]) drive_hit(hits[i].id, hits[i].t, 1'b0);
    rand_hits(40);
    chk("err_clean", 64'(err), 64'd0);
    finish_run("run1_done");
    busy_done = busy;
    foreach (rds[i]) read_one(rds[i].addr, rds[i].exp);
    sweep();
    chk("busy_hold", busy, busy_done);

    // run 2: out-of-range id, hit together with finish
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    wait_ready();
    chk("err_pre", 64'(err), 64'd0);
    drive_hit(32'd4096, 32'h3F00_0000, 1'b0);
    chk("err_set", 64'(err), 64'd1);
    drive_hit(32'd1023, 32'h3F00_0000, 1'b0);
    drive_hit(32'hFFFF_FFFF, 32'h3F00_0000, 1'b0);
    chk("err_sticky", 64'(err), 64'd1);
    drive_hit(32'd9, 32'h3F00_0000, 1'b1);
    wait_done("t5_done", 20, n5);
    chk("t5_latency_le3", 64'(n5 + 1 <= 3), 64'd1);
    read_one(9, 32'h3F00_0000);
    read_one(0, INF);
    sweep();

    // run 3: reset dropped mid-RUN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    wait_ready();
    rand_hits(50);
    rst_n = 1'b0;
    #1;
    chk("t6_ready", 64'(ready), 64'd0);
    chk("t6_busy",  busy,       64'd0);
    chk("t6_err",   64'(err),   64'd0);
    @(negedge clk);
    chk("t6_done",  64'(done),  64'd0);
    rst_n = 1'b1;
    model_clear();
    wait_ready();
    finish_run("t6_fin");
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
